fetch_unit: RTL and testbench

- Instruction-fetch stage of the single-cycle/pipelined MIPS datapath; sits directly upstream of the instruction ROM.
- Owns the PC, drives the ROM word address, and captures the ROM's negedge-registered output into an IF/ID register.
- Handles sequential, branch and jump redirects, stall, halt, and address faults.
- Tracks a valid bit and an issued-instruction counter for the decode stage and the bench.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM word address and
// registers the returned word into the IF/ID register with a valid bit.
module fetch_unit #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] issue_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALT   = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] plus4_q, plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] count_q, count_d;

    logic [31:0] seq_pc;
    logic        redirect;
    logic [31:0] redirect_target;

    // A target is legal only if word aligned and inside the ROM word range.
    function automatic logic target_illegal(input logic [31:0] t);
        logic [31:0] hi;
        hi = t >> (ADDR_WIDTH + 2);
        return (t[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

    assign seq_pc          = pc_q + 32'd4;
    assign redirect        = jump || branch_taken;
    assign redirect_target = jump ? jump_target : branch_target;

    // stall is a plain hold, not a handshake: while it is high nothing in
    // this stage moves, and any redirect presented alongside it is dropped.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        plus4_d      = plus4_q;
        valid_d      = valid_q;
        fault_addr_d = fault_addr_q;
        count_d      = count_q;
        unique case (state_q)
            ST_WARMUP: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end else if (stall) begin
                    state_d = ST_RUN;
                end else if (redirect) begin
                    // The sequential word fetched this cycle is squashed.
                    valid_d = 1'b0;
                    if (target_illegal(redirect_target)) begin
                        state_d      = ST_FAULT;
                        fault_addr_d = redirect_target;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else begin
                    inst_d    = inst_in;
                    inst_pc_d = pc_q;
                    plus4_d   = seq_pc;
                    valid_d   = 1'b1;
                    count_d   = count_q + 32'd1;
                    if (target_illegal(seq_pc)) begin
                        state_d      = ST_FAULT;
                        fault_addr_d = seq_pc;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
            end
            ST_FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_WARMUP;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            plus4_q      <= 32'd0;
            valid_q      <= 1'b0;
            fault_addr_q <= 32'd0;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            plus4_q      <= plus4_d;
            valid_q      <= valid_d;
            fault_addr_q <= fault_addr_d;
            count_q      <= count_d;
        end
    end

    assign pc_out      = pc_q;
    assign inst_out    = inst_q;
    assign inst_pc     = inst_pc_q;
    assign pc_plus4    = plus4_q;
    assign inst_valid  = valid_q;
    assign halted      = (state_q == ST_HALT);
    assign fault       = (state_q == ST_FAULT);
    assign fault_addr  = fault_addr_q;
    assign issue_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a negedge ROM model feeds inst_in and each
// scenario task checks the stage outputs against hand-computed values.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        halt;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] inst_in;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] issue_count;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [256];

    fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .inst_in(inst_in),
        .pc_out(pc_out), .inst_out(inst_out), .inst_pc(inst_pc),
        .pc_plus4(pc_plus4), .inst_valid(inst_valid), .halted(halted),
        .fault(fault), .fault_addr(fault_addr), .issue_count(issue_count),
        .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word i of the ROM holds C0DE_0000 + i.
    initial for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 + i;
    always @(negedge clock) inst_in <= rom[pc_out[9:2]];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    // Reset, release, and consume the warm-up edge; leaves the DUT in RUN at pc 0.
    task automatic start_run();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h want %h", pc_out, 32'h0); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst_out: got %h want %h", inst_out, 32'h0); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want %h", inst_pc, 32'h0); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h0); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (fault_addr !== 32'h0) begin errors++; $display("FAIL reset_fault_addr: got %h want %h", fault_addr, 32'h0); end
        checks++; if (issue_count !== 32'h0) begin errors++; $display("FAIL reset_issue_count: got %h want %h", issue_count, 32'h0); end
    endtask

    task automatic test_sequential();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL warmup_valid: got %b want 0", inst_valid); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL warmup_pc: got %h want %h", pc_out, 32'h0); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (inst_out !== 32'hC0DE_0000 + i) begin errors++; $display("FAIL seq_inst[%0d]: got %h want %h", i, inst_out, 32'hC0DE_0000 + i); end
            checks++; if (inst_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_inst_pc[%0d]: got %h want %h", i, inst_pc, 4 * i); end
            checks++; if (pc_plus4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL seq_pc_plus4[%0d]: got %h want %h", i, pc_plus4, 4 * i + 4); end
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, inst_valid); end
        end
        checks++; if (issue_count !== 32'd4) begin errors++; $display("FAIL seq_count: got %0d want 4", issue_count); end
    endtask

    task automatic test_stall();
        start_run();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc_out, 32'h8); end
            checks++; if (inst_out !== 32'hC0DE_0001) begin errors++; $display("FAIL stall_inst[%0d]: got %h want %h", i, inst_out, 32'hC0DE_0001); end
            checks++; if (issue_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 2", i, issue_count); end
        end
        stall = 1'b0;
        step();
        checks++; if (inst_out !== 32'hC0DE_0002) begin errors++; $display("FAIL stall_release_inst: got %h want %h", inst_out, 32'hC0DE_0002); end
        checks++; if (inst_pc !== 32'h8) begin errors++; $display("FAIL stall_release_pc: got %h want %h", inst_pc, 32'h8); end
        step();
        checks++; if (inst_out !== 32'hC0DE_0003) begin errors++; $display("FAIL stall_next_inst: got %h want %h", inst_out, 32'hC0DE_0003); end
    endtask

    task automatic test_redirect();
        start_run();
        step();
        step();
        branch_taken = 1'b1; branch_target = 32'h20;
        step();
        branch_taken = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL branch_bubble: got %b want 0", inst_valid); end
        checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL branch_pc: got %h want %h", pc_out, 32'h20); end
        checks++; if (issue_count !== 32'd2) begin errors++; $display("FAIL branch_count: got %0d want 2", issue_count); end
        step();
        checks++; if (inst_out !== 32'hC0DE_0008) begin errors++; $display("FAIL branch_inst: got %h want %h", inst_out, 32'hC0DE_0008); end
        checks++; if (inst_pc !== 32'h20) begin errors++; $display("FAIL branch_inst_pc: got %h want %h", inst_pc, 32'h20); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL branch_valid: got %b want 1", inst_valid); end
        jump = 1'b1; jump_target = 32'h40;
        branch_taken = 1'b1; branch_target = 32'h80;
        step();
        idle_inputs();
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL jump_wins_pc: got %h want %h", pc_out, 32'h40); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jump_bubble: got %b want 0", inst_valid); end
        step();
        checks++; if (inst_out !== 32'hC0DE_0010) begin errors++; $display("FAIL jump_inst: got %h want %h", inst_out, 32'hC0DE_0010); end
        checks++; if (inst_pc !== 32'h40) begin errors++; $display("FAIL jump_inst_pc: got %h want %h", inst_pc, 32'h40); end
    endtask

    task automatic test_fault_target();
        start_run();
        step();
        jump = 1'b1; jump_target = 32'h22;
        step();
        idle_inputs();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL misalign_fault: got %b want 1", fault); end
        checks++; if (fault_addr !== 32'h22) begin errors++; $display("FAIL misalign_addr: got %h want %h", fault_addr, 32'h22); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL misalign_valid: got %b want 0", inst_valid); end
        checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL misalign_pc: got %h want %h", pc_out, 32'h4); end
        branch_taken = 1'b1; branch_target = 32'h0;
        step();
        step();
        idle_inputs();
        checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL fault_frozen_pc: got %h want %h", pc_out, 32'h4); end
        checks++; if (issue_count !== 32'd1) begin errors++; $display("FAIL fault_frozen_count: got %0d want 1", issue_count); end
        checks++; if (inst_out !== 32'hC0DE_0000) begin errors++; $display("FAIL fault_frozen_inst: got %h want %h", inst_out, 32'hC0DE_0000); end
        checks++; if (fault_addr !== 32'h22) begin errors++; $display("FAIL fault_frozen_addr: got %h want %h", fault_addr, 32'h22); end
        start_run();
        jump = 1'b1; jump_target = 32'h400;
        step();
        idle_inputs();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL range_fault: got %b want 1", fault); end
        checks++; if (fault_addr !== 32'h400) begin errors++; $display("FAIL range_addr: got %h want %h", fault_addr, 32'h400); end
    endtask

    task automatic test_wrap();
        start_run();
        for (int i = 0; i < 255; i++) step();
        checks++; if (pc_out !== 32'h3FC) begin errors++; $display("FAIL wrap_pc_before: got %h want %h", pc_out, 32'h3FC); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wrap_early_fault: got %b want 0", fault); end
        step();
        checks++; if (inst_out !== 32'hC0DE_00FF) begin errors++; $display("FAIL wrap_last_inst: got %h want %h", inst_out, 32'hC0DE_00FF); end
        checks++; if (inst_pc !== 32'h3FC) begin errors++; $display("FAIL wrap_last_pc: got %h want %h", inst_pc, 32'h3FC); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_last_valid: got %b want 1", inst_valid); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wrap_fault: got %b want 1", fault); end
        checks++; if (fault_addr !== 32'h400) begin errors++; $display("FAIL wrap_addr: got %h want %h", fault_addr, 32'h400); end
        checks++; if (issue_count !== 32'd256) begin errors++; $display("FAIL wrap_count: got %0d want 256", issue_count); end
        step();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wrap_after_valid: got %b want 0", inst_valid); end
        checks++; if (issue_count !== 32'd256) begin errors++; $display("FAIL wrap_after_count: got %0d want 256", issue_count); end
    endtask

    task automatic test_halt();
        start_run();
        step();
        step();
        halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
        step();
        idle_inputs();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL halt_pc: got %h want %h", pc_out, 32'h8); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b want 0", inst_valid); end
        step();
        step();
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL halt_hold_pc: got %h want %h", pc_out, 32'h8); end
        checks++; if (issue_count !== 32'd2) begin errors++; $display("FAIL halt_hold_count: got %0d want 2", issue_count); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold_flag: got %b want 1", halted); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL async_halted: got %b want 0", halted); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL async_pc: got %h want %h", pc_out, 32'h0); end
        checks++; if (issue_count !== 32'h0) begin errors++; $display("FAIL async_count: got %h want %h", issue_count, 32'h0); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL async_inst: got %h want %h", inst_out, 32'h0); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL async_inst_pc: got %h want %h", inst_pc, 32'h0); end
        step();
        reset = 1'b1;
        step();
        step();
        checks++; if (inst_out !== 32'hC0DE_0000) begin errors++; $display("FAIL resume_inst: got %h want %h", inst_out, 32'hC0DE_0000); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL resume_valid: got %b want 1", inst_valid); end
        checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL resume_pc: got %h want %h", pc_out, 32'h4); end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault_target();
        test_wrap();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
